// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for VGA pong (serve, scoring, speed level, winner).
// Define PONG_AUTO_SERVE_EN to let SERVE_WAIT serve by itself after AUTO_SERVE_FRAMES frames.
module pong_match_ctrl #(
  parameter int WIN_SCORE         = 7,
  parameter int POINT_FRAMES      = 60,
  parameter int SPEEDUP_HITS      = 4,
  parameter int MAX_SPEED         = 3,
  parameter int AUTO_SERVE_FRAMES = 120
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_btn_serve,
  input  logic       i_btn_rst,
  input  logic       i_miss_left,
  input  logic       i_miss_right,
  input  logic       i_paddle_hit,
  output logic       o_ball_run,
  output logic       o_ball_reset,
  output logic       o_serve_dir,
  output logic [3:0] o_score_l,
  output logic [3:0] o_score_r,
  output logic [1:0] o_speed_lvl,
  output logic       o_winner_vld,
  output logic       o_winner,
  output logic [2:0] o_state
);
  localparam int FMAX = POINT_FRAMES > AUTO_SERVE_FRAMES ? POINT_FRAMES : AUTO_SERVE_FRAMES;
  localparam int CW = $clog2(FMAX + 1);
  localparam int HW = $clog2(SPEEDUP_HITS + 1);
`ifdef PONG_AUTO_SERVE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    OVER       = 3'd4
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic          r_sync_d;
  logic [3:0]    r_score_l, r_score_r, w_score_l, w_score_r;
  logic [1:0]    r_speed, w_speed;
  logic [HW-1:0] r_hit, w_hit;
  logic [CW-1:0] r_frm, w_frm;
  logic          r_dir, w_dir;
  logic          w_serve_p, w_point_done, w_auto, w_frm_inc, w_hit_wrap;

  assign w_serve_p    = r_sync[1] & ~r_sync_d;
  assign w_point_done = i_frame_tick && r_frm == CW'(POINT_FRAMES - 1);
  assign w_auto       = AUTO_EN && i_frame_tick && r_frm == CW'(AUTO_SERVE_FRAMES - 1);
  assign w_frm_inc    = i_frame_tick && (r_state == POINT || (AUTO_EN && r_state == SERVE_WAIT));
  assign w_hit_wrap   = r_hit == HW'(SPEEDUP_HITS - 1);
  // Any state change restarts the frame count, so each state sees frames since its own entry.
  assign w_frm        = (i_btn_rst || w_state != r_state) ? '0 : w_frm_inc ? r_frm + CW'(1) : r_frm;

  always_comb begin
    w_state   = r_state;
    w_score_l = r_score_l;
    w_score_r = r_score_r;
    w_speed   = r_speed;
    w_hit     = r_hit;
    w_dir     = r_dir;
    if (i_btn_rst) begin
      w_state   = IDLE;
      w_score_l = '0;
      w_score_r = '0;
      w_speed   = '0;
      w_hit     = '0;
    end else begin
      case (r_state)
        IDLE: w_state = w_serve_p ? PLAY : IDLE;
        SERVE_WAIT: if (w_serve_p || w_auto) begin
          w_state = PLAY;
          w_speed = '0;
          w_hit   = '0;
        end
        PLAY: if (i_miss_left || i_miss_right) begin
          w_state = POINT;
          if (i_miss_right && !i_miss_left) begin
            w_score_l = r_score_l == 4'hf ? r_score_l : r_score_l + 4'd1;
            w_dir     = 1'b1;
          end else if (i_miss_left && !i_miss_right) begin
            w_score_r = r_score_r == 4'hf ? r_score_r : r_score_r + 4'd1;
            w_dir     = 1'b0;
          end
        end else if (i_paddle_hit) begin
          w_hit   = w_hit_wrap ? '0 : r_hit + HW'(1);
          w_speed = (w_hit_wrap && r_speed < 2'(MAX_SPEED)) ? r_speed + 2'd1 : r_speed;
        end
        POINT: if (w_point_done)
          w_state = (r_score_l >= 4'(WIN_SCORE) || r_score_r >= 4'(WIN_SCORE)) ? OVER : SERVE_WAIT;
        OVER: if (w_serve_p) begin
          w_state   = SERVE_WAIT;
          w_score_l = '0;
          w_score_r = '0;
          w_speed   = '0;
          w_hit     = '0;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_sync    <= '0;
      r_sync_d  <= 1'b0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_speed   <= '0;
      r_hit     <= '0;
      r_frm     <= '0;
      r_dir     <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_sync    <= {r_sync[0], i_btn_serve};
      r_sync_d  <= r_sync[1];
      r_score_l <= w_score_l;
      r_score_r <= w_score_r;
      r_speed   <= w_speed;
      r_hit     <= w_hit;
      r_frm     <= w_frm;
      r_dir     <= w_dir;
    end
  end

  assign o_ball_run   = r_state == PLAY;
  assign o_ball_reset = r_state != PLAY;
  assign o_serve_dir  = r_dir;
  assign o_score_l    = r_score_l;
  assign o_score_r    = r_score_r;
  assign o_speed_lvl  = r_speed;
  assign o_winner_vld = r_state == OVER;
  assign o_winner     = r_state == OVER && r_score_r >= 4'(WIN_SCORE);
  assign o_state      = r_state;
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the VGA pong design.
- Sits between the button inputs, the ball/paddle physics and the renderer.
- Decides when the ball moves, when it is re-centred and which way it serves; keeps the score and ball speed level; declares the winner.
- All timing is counted in video frames, using a one-cycle frame_tick pulse from the VGA timing generator.

Parameters:
WIN_SCORE, 7, points needed to win (1..15)
POINT_FRAMES, 60, frames the ball stays frozen after a point
SPEEDUP_HITS, 4, paddle hits per speed-level increment
MAX_SPEED, 3, saturation value of speed_lvl (<=3)
AUTO_SERVE_FRAMES, 120, frames before auto serve (only when the optional feature is compiled in)

Ports:
clock  in  1  pixel clock, 25 MHz
reset  in  1  asynchronous, active-low; low = reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
btn_serve  in  1  raw serve button, active-high, asynchronous
btn_rst  in  1  game reset, active-high, already synchronised, level
miss_left  in  1  one-cycle pulse: ball passed the left edge
miss_right  in  1  one-cycle pulse: ball passed the right edge
paddle_hit  in  1  one-cycle pulse: ball bounced off either paddle
ball_run  out  1  ball moves while high
ball_reset  out  1  high = physics holds the ball at centre
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
score_l  out  4  left player score
score_r  out  4  right player score
speed_lvl  out  2  ball speed level
winner_vld  out  1  high in OVER
winner  out  1  0 = left won, 1 = right won; valid when winner_vld
state_o  out  3  IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Reset (reset low, async):
  - state IDLE.
  - ball_run=0, ball_reset=1, serve_dir=1.
  - Scores, speed_lvl, hit and frame counters all 0.
  - winner_vld=0, winner=0.
- Serve edge:
  - btn_serve passes through a 2-FF synchroniser, then a rising-edge detector, producing serve_p.
  - A press therefore changes state on the 3rd clock edge after btn_serve rises.
  - A held button produces exactly one serve_p.
- btn_rst:
  - Highest priority, acts synchronously.
  - While high: state IDLE, scores and speed 0, winner_vld 0, all counters 0.
- IDLE:
  - ball_reset=1, ball_run=0.
  - serve_p -> PLAY.
- SERVE_WAIT:
  - ball_reset=1, ball_run=0.
  - serve_p -> PLAY. On that transition speed_lvl and the hit counter clear.
- PLAY:
  - ball_run=1, ball_reset=0.
  - paddle_hit increments the hit counter. When it reaches SPEEDUP_HITS, the counter returns to 0 and speed_lvl increments, saturating at MAX_SPEED.
  - miss_right alone: score_l+1, serve_dir=1 -> POINT.
  - miss_left alone: score_r+1, serve_dir=0 -> POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged -> POINT.
  - A miss in the same cycle as paddle_hit: the miss wins; the hit is ignored.
  - Score updates saturate at 15.
- POINT:
  - ball_run=0, ball_reset=1.
  - Frame counter clears on entry and counts frame_tick.
  - On the POINT_FRAMES-th tick: if score_l or score_r >= WIN_SCORE -> OVER, else -> SERVE_WAIT.
  - serve_p is ignored in POINT.
- OVER:
  - winner_vld=1; winner=1 if score_r >= WIN_SCORE, else 0.
  - ball_reset=1.
  - serve_p clears both scores, speed_lvl and winner_vld, then -> SERVE_WAIT.
- Pulses outside their state are ignored:
  - misses and hits outside PLAY;
  - frame_tick outside POINT (and outside SERVE_WAIT when AUTO_SERVE_EN is defined).
- Outputs are registered. Each is a pure function of the state/score registers, with no combinational path from inputs.

Optional Feature:
PONG_AUTO_SERVE_EN
- Defined:
  - SERVE_WAIT also counts frame_tick; the counter clears on entry.
  - Reaching AUTO_SERVE_FRAMES acts as serve_p.
  - A real serve_p before that takes effect immediately.
  - IDLE and OVER still require a press.
- Undefined: the counter logic is absent; SERVE_WAIT waits indefinitely for serve_p.

Test Plan:
- Reset low mid-PLAY with score_l=3 -> immediately state_o=0, score_l=0, ball_run=0, ball_reset=1; stays so after reset rises until a serve press.
- Hold btn_serve high 100 cycles in IDLE -> state_o=2 exactly 3 clocks after the rising edge; single transition, no second serve.
- In PLAY pulse miss_right -> score_l=1, serve_dir=1, state_o=3; after 59 frame_ticks still POINT; on the 60th -> state_o=1.
- Pulse miss_left and miss_right in the same cycle -> scores unchanged, state_o=3.
- 9 paddle_hits in PLAY -> speed_lvl=2; 20 more -> speed_lvl=3 (saturated); next serve -> 0.
- Right scores 7 points -> after the POINT timeout state_o=4, winner_vld=1, winner=1; a serve press clears scores -> state_o=1. With PONG_AUTO_SERVE_EN: 120 frame_ticks in SERVE_WAIT -> state_o=2 with no press.
